// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types for the fetch/data memory arbiter
// Purpose: FSM state, owner encoding and byte-lane word type.
// Ports: none (package).
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ACCESS,
    ARB_DONE
  } arb_state_t;

  typedef enum logic {
    OWNER_IF,
    OWNER_D
  } owner_t;

  // Byte 0 is the most significant byte of the packed word.
  typedef logic [0:3][7:0] byte_lanes_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - fetch, data and memory port bundle of the arbiter
// Purpose: groups every non-clock signal of mem_arbiter.
// Ports (signals): halt; if_req/if_addr/if_rdata/if_ack; d_req/d_we/d_addr/
//   d_wdata/d_rdata/d_ack; mem_en/mem_addr/mem_data_in/mem_write_en/
//   mem_data_out; busy.
//   slave  : arbiter side.
//   master : core + memory model side.
interface mem_arbiter_if;
  import mem_arb_pkg::*;

  logic        halt;
  logic        if_req;
  logic [31:0] if_addr;
  byte_lanes_t if_rdata;
  logic        if_ack;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  byte_lanes_t d_wdata;
  byte_lanes_t d_rdata;
  logic        d_ack;
  logic        mem_en;
  logic [31:0] mem_addr;
  byte_lanes_t mem_data_in;
  logic        mem_write_en;
  byte_lanes_t mem_data_out;
  logic        busy;

  modport slave (
    input  halt, if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_data_out,
    output if_rdata, if_ack, d_rdata, d_ack, mem_en, mem_addr, mem_data_in,
           mem_write_en, busy
  );

  modport master (
    output halt, if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_data_out,
    input  if_rdata, if_ack, d_rdata, d_ack, mem_en, mem_addr, mem_data_in,
           mem_write_en, busy
  );

endinterface

// File: rtl/mem_arbiter_pick.sv
// rtl/mem_arbiter_pick.sv - combinational grant picker for the arbiter
// Purpose: chooses which eligible requester wins an idle cycle.
// Ports:
//   eligible_if, eligible_d : requester may be granted this cycle
//   last_grant              : owner of the previous grant
//   grant_valid             : at least one requester is eligible
//   grant_owner             : winning owner (meaningful when grant_valid)
module arb_pick
  import mem_arb_pkg::*;
#(
  parameter int DATA_PRIO = 1
) (
  input  logic   eligible_if,
  input  logic   eligible_d,
  input  owner_t last_grant,
  output logic   grant_valid,
  output owner_t grant_owner
);

  always_comb begin
    grant_valid = eligible_if | eligible_d;
    grant_owner = OWNER_D;
    if (eligible_if && eligible_d) begin
      // Round-robin hands the conflict to whoever did not win last time.
      if (DATA_PRIO == 0 && last_grant == OWNER_D) begin
        grant_owner = OWNER_IF;
      end
    end else if (eligible_if) begin
      grant_owner = OWNER_IF;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shares one fixed-latency memory between fetch and data ports
// Purpose: grants one requester at a time, runs one memory access, returns
//   a one-cycle ack to the owner with the read bytes registered.
// Ports:
//   clk   : clock, rising edge
//   rst_b : asynchronous active-low reset
//   bus   : mem_arbiter_if.slave (fetch port, data port, memory port, busy)
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MEM_LATENCY = 2,
  parameter int DATA_PRIO   = 1
) (
  input logic          clk,
  input logic          rst_b,
  mem_arbiter_if.slave bus
);

  localparam int               CNT_W    = $clog2(MEM_LATENCY + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY - 1);

  arb_state_t       state_q, state_d;
  owner_t           owner_q, owner_d;
  owner_t           last_q, last_d;
  logic [31:0]      addr_q, addr_d;
  logic             we_q, we_d;
  byte_lanes_t      wdata_q, wdata_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  byte_lanes_t      if_rdata_q, if_rdata_d;
  byte_lanes_t      d_rdata_q, d_rdata_d;

  logic   grant_valid;
  owner_t grant_owner;

  arb_pick #(
    .DATA_PRIO(DATA_PRIO)
  ) u_pick (
    .eligible_if (bus.if_req & ~bus.halt),
    .eligible_d  (bus.d_req),
    .last_grant  (last_q),
    .grant_valid (grant_valid),
    .grant_owner (grant_owner)
  );

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q    <= ARB_IDLE;
      owner_q    <= OWNER_IF;
      last_q     <= OWNER_D;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      cnt_q      <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      last_q     <= last_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      cnt_q      <= cnt_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    owner_d          = owner_q;
    last_d           = last_q;
    addr_d           = addr_q;
    we_d             = we_q;
    wdata_d          = wdata_q;
    cnt_d            = cnt_q;
    if_rdata_d       = if_rdata_q;
    d_rdata_d        = d_rdata_q;
    bus.mem_en       = 1'b0;
    bus.mem_addr     = '0;
    bus.mem_data_in  = '0;
    bus.mem_write_en = 1'b0;
    bus.if_ack       = 1'b0;
    bus.d_ack        = 1'b0;

    unique case (state_q)
      ARB_IDLE: begin
        if (grant_valid) begin
          owner_d = grant_owner;
          last_d  = grant_owner;
          addr_d  = (grant_owner == OWNER_D) ? bus.d_addr : bus.if_addr;
          we_d    = (grant_owner == OWNER_D) & bus.d_we;
          wdata_d = bus.d_wdata;
          cnt_d   = CNT_LOAD;
          state_d = ARB_ACCESS;
        end
      end

      ARB_ACCESS: begin
        // The counter only counts down, so holding its load value marks
        // the first access cycle, the only one that strobes the memory.
        if (cnt_q == CNT_LOAD) begin
          bus.mem_en       = 1'b1;
          bus.mem_addr     = addr_q;
          bus.mem_data_in  = wdata_q;
          bus.mem_write_en = we_q;
        end
        if (cnt_q == '0) begin
          if (!we_q) begin
            if (owner_q == OWNER_IF) begin
              if_rdata_d = bus.mem_data_out;
            end else begin
              d_rdata_d = bus.mem_data_out;
            end
          end
          state_d = ARB_DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      ARB_DONE: begin
        // Requests are not sampled here, so a requester that drops req on
        // its ack is never granted a second time.
        bus.if_ack = (owner_q == OWNER_IF);
        bus.d_ack  = (owner_q == OWNER_D);
        state_d    = ARB_IDLE;
      end

      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  assign bus.if_rdata = if_rdata_q;
  assign bus.d_rdata  = d_rdata_q;
  assign bus.busy     = (state_q != ARB_IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter (priority and round-robin)
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int L = 2;

  logic clk = 1'b0;
  logic rst_b;
  always #5 clk = ~clk;

  logic        halt_v    [2];
  logic        if_req_v  [2];
  logic [31:0] if_addr_v [2];
  logic        d_req_v   [2];
  logic        d_we_v    [2];
  logic [31:0] d_addr_v  [2];
  logic [31:0] d_wdata_v [2];

  logic [1:0]  o_if_ack, o_d_ack, o_mem_en, o_mem_we, o_busy;
  logic [31:0] o_if_rdata [2];
  logic [31:0] o_d_rdata  [2];
  logic [31:0] o_mem_addr [2];
  logic [31:0] o_mem_din  [2];

  function automatic logic [31:0] init_word(input int k, input int idx);
    if (idx == 16) return 32'h8C01_0004;
    return (32'(idx) * 32'h9E37_79B1) ^ (32'(k) << 28) ^ 32'h1234_5678;
  endfunction

  for (genvar k = 0; k < 2; k++) begin : g_inst
    mem_arbiter_if bus ();

    mem_arbiter #(
      .MEM_LATENCY(L),
      .DATA_PRIO((k == 0) ? 1 : 0)
    ) u_dut (
      .clk   (clk),
      .rst_b (rst_b),
      .bus   (bus)
    );

    assign bus.halt    = halt_v[k];
    assign bus.if_req  = if_req_v[k];
    assign bus.if_addr = if_addr_v[k];
    assign bus.d_req   = d_req_v[k];
    assign bus.d_we    = d_we_v[k];
    assign bus.d_addr  = d_addr_v[k];
    assign bus.d_wdata = d_wdata_v[k];

    assign o_if_ack[k]   = bus.if_ack;
    assign o_d_ack[k]    = bus.d_ack;
    assign o_mem_en[k]   = bus.mem_en;
    assign o_mem_we[k]   = bus.mem_write_en;
    assign o_busy[k]     = bus.busy;
    assign o_if_rdata[k] = bus.if_rdata;
    assign o_d_rdata[k]  = bus.d_rdata;
    assign o_mem_addr[k] = bus.mem_addr;
    assign o_mem_din[k]  = bus.mem_data_in;

    // Memory model: samples on the enable edge, read data held until the next read.
    logic [31:0] env_mem [256];
    bit          env_wr  [256];
    logic [31:0] rd_q;
    always @(posedge clk) begin
      if (bus.mem_en) begin
        if (bus.mem_write_en) begin
          env_mem[bus.mem_addr[9:2]] <= bus.mem_data_in;
          env_wr[bus.mem_addr[9:2]]  <= 1'b1;
        end else begin
          rd_q <= env_wr[bus.mem_addr[9:2]] ? env_mem[bus.mem_addr[9:2]]
                                            : init_word(k, int'(bus.mem_addr[9:2]));
        end
      end
    end
    assign bus.mem_data_out = rd_q;
  end

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Transaction-level reference: one access in flight, timed from its grant edge.
  logic [31:0] ref_mem [2][256];
  int          gnt_cyc [2];
  int          free_at [2];
  bit          gnt_d   [2];
  bit          gnt_we  [2];
  logic [31:0] gnt_addr  [2];
  logic [31:0] gnt_wdata [2];
  bit          last_d  [2];
  logic [31:0] exp_if_rd [2];
  logic [31:0] exp_d_rd  [2];
  bit          out_if  [2];
  bit          out_d   [2];

  int ack_who[$];
  int ackif_at, ackd_at, en_at, n_en, n_we, n_dack;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_tests++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      gnt_cyc[k]   = -1;
      free_at[k]   = 0;
      last_d[k]    = 1'b1;
      exp_if_rd[k] = '0;
      exp_d_rd[k]  = '0;
      out_if[k]    = 1'b0;
      out_d[k]     = 1'b0;
      halt_v[k]    = 1'b0;
      if_req_v[k]  = 1'b0;
      d_req_v[k]   = 1'b0;
      d_we_v[k]    = 1'b0;
      if_addr_v[k] = '0;
      d_addr_v[k]  = '0;
      d_wdata_v[k] = '0;
    end
  endtask

  task automatic tick(input int k);
    bit e_en, e_busy, acking, take_d, el_if, el_d;
    @(negedge clk);
    e_en   = (gnt_cyc[k] >= 0) && (cyc == gnt_cyc[k] + 1);
    e_busy = (gnt_cyc[k] >= 0) && (cyc > gnt_cyc[k]);
    acking = (gnt_cyc[k] >= 0) && (cyc == gnt_cyc[k] + L + 1);
    if (acking) begin
      if (gnt_we[k]) ref_mem[k][gnt_addr[k][9:2]] = gnt_wdata[k];
      else if (gnt_d[k]) exp_d_rd[k] = ref_mem[k][gnt_addr[k][9:2]];
      else exp_if_rd[k] = ref_mem[k][gnt_addr[k][9:2]];
    end
    chk("mem_en", 32'(o_mem_en[k]), 32'(e_en));
    chk("mem_write_en", 32'(o_mem_we[k]), 32'(e_en && gnt_we[k]));
    if (e_en) chk("mem_addr", o_mem_addr[k], gnt_addr[k]);
    if (e_en && gnt_we[k]) chk("mem_data_in", o_mem_din[k], gnt_wdata[k]);
    chk("busy", 32'(o_busy[k]), 32'(e_busy));
    chk("if_ack", 32'(o_if_ack[k]), 32'(acking && !gnt_d[k]));
    chk("d_ack", 32'(o_d_ack[k]), 32'(acking && gnt_d[k]));
    chk("if_rdata", o_if_rdata[k], exp_if_rd[k]);
    chk("d_rdata", o_d_rdata[k], exp_d_rd[k]);
    if (o_if_ack[k]) begin ack_who.push_back(0); ackif_at = cyc; end
    if (o_d_ack[k])  begin ack_who.push_back(1); ackd_at = cyc; n_dack++; end
    if (o_mem_en[k]) begin en_at = cyc; n_en++; end
    if (o_mem_we[k]) n_we++;
    if (acking) begin
      gnt_cyc[k] = -1;
      free_at[k] = cyc + 1;
      if (gnt_d[k]) out_d[k] = 1'b0;
      else out_if[k] = 1'b0;
    end else if (gnt_cyc[k] < 0 && cyc >= free_at[k]) begin
      el_if = if_req_v[k] && !halt_v[k];
      el_d  = d_req_v[k];
      if (el_if || el_d) begin
        // Data wins alone, under fixed priority, or when fetch won last time.
        take_d        = el_d && (!el_if || k == 0 || !last_d[k]);
        gnt_cyc[k]    = cyc;
        gnt_d[k]      = take_d;
        gnt_addr[k]   = take_d ? d_addr_v[k] : if_addr_v[k];
        gnt_we[k]     = take_d && d_we_v[k];
        gnt_wdata[k]  = d_wdata_v[k];
        last_d[k]     = take_d;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic req_if(input int k, input logic [31:0] addr);
    if_req_v[k] = 1'b1; if_addr_v[k] = addr; out_if[k] = 1'b1;
  endtask

  task automatic req_d(input int k, input logic we, input logic [31:0] addr, input logic [31:0] wd);
    d_req_v[k] = 1'b1; d_we_v[k] = we; d_addr_v[k] = addr; d_wdata_v[k] = wd; out_d[k] = 1'b1;
  endtask

  task automatic drive_hold(input int k);
    if (!out_if[k]) if_req_v[k] = 1'b0;
    if (!out_d[k])  d_req_v[k]  = 1'b0;
  endtask

  task automatic drive_rand(input int k);
    if (!out_if[k]) begin
      if ($urandom_range(99) < 40) req_if(k, $urandom);
      else if_req_v[k] = 1'b0;
    end else if (gnt_cyc[k] >= 0 && !gnt_d[k] && $urandom_range(3) == 0) begin
      if_req_v[k] = 1'b0;
    end
    if (!out_d[k]) begin
      if ($urandom_range(99) < 40) req_d(k, 1'($urandom_range(1)), $urandom, $urandom);
      else d_req_v[k] = 1'b0;
    end else if (gnt_cyc[k] >= 0 && gnt_d[k] && $urandom_range(3) == 0) begin
      d_req_v[k] = 1'b0;
    end
    if ($urandom_range(15) == 0) halt_v[k] = !halt_v[k];
  endtask

  task automatic drain(input int k, input int bound);
    for (int i = 0; i < bound && (out_if[k] || out_d[k]); i++) begin
      drive_hold(k);
      tick(k);
    end
    drive_hold(k);
    chk("drain_timeout", 32'({out_if[k], out_d[k]}), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    rst_b = 1'b0;
    model_reset();
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 256; i++) ref_mem[k][i] = init_word(k, i);
    #12;
    for (int k = 0; k < 2; k++) begin
      chk("rst_busy", 32'(o_busy[k]), 32'd0);
      chk("rst_mem_en", 32'(o_mem_en[k]), 32'd0);
      chk("rst_mem_we", 32'(o_mem_we[k]), 32'd0);
      chk("rst_acks", 32'({o_if_ack[k], o_d_ack[k]}), 32'd0);
      chk("rst_if_rdata", o_if_rdata[k], 32'd0);
      chk("rst_d_rdata", o_d_rdata[k], 32'd0);
      chk("rst_mem_addr", o_mem_addr[k], 32'd0);
    end
    rst_b = 1'b1;
    @(posedge clk);
    #1;

    // Single fetch from 0x40.
    s = cyc; n_en = 0; ackif_at = -1;
    req_if(0, 32'h40);
    drain(0, 20);
    chk("fetch_ack_latency", 32'(ackif_at), 32'(s + 3));
    chk("fetch_en_count", 32'(n_en), 32'd1);
    chk("fetch_rdata", o_if_rdata[0], 32'h8C01_0004);

    // Simultaneous fetch and load with fixed data priority.
    s = cyc; ackif_at = -1; ackd_at = -1; en_at = -1;
    req_if(0, 32'h48);
    req_d(0, 1'b0, 32'h100, 32'h0);
    drain(0, 30);
    chk("prio_d_ack", 32'(ackd_at), 32'(s + 3));
    chk("prio_if_mem_en", 32'(en_at), 32'(s + 5));
    chk("prio_if_ack", 32'(ackif_at), 32'(s + 7));

    // Load, then store, then read the store back.
    req_d(0, 1'b0, 32'h300, 32'h0);
    drain(0, 20);
    chk("load_0x300", o_d_rdata[0], init_word(0, 192));
    n_dack = 0; n_we = 0;
    req_d(0, 1'b1, 32'h200, 32'hDEAD_BEEF);
    drain(0, 20);
    chk("store_ack_count", 32'(n_dack), 32'd1);
    chk("store_we_count", 32'(n_we), 32'd1);
    chk("store_keeps_d_rdata", o_d_rdata[0], init_word(0, 192));
    req_d(0, 1'b0, 32'h200, 32'h0);
    drain(0, 20);
    chk("store_readback", o_d_rdata[0], 32'hDEAD_BEEF);

    // Halt blocks fetch grants but not data.
    halt_v[0] = 1'b1; n_en = 0;
    req_if(0, 32'h44);
    repeat (10) begin drive_hold(0); tick(0); end
    chk("halt_no_mem_en", 32'(n_en), 32'd0);
    chk("halt_busy", 32'(o_busy[0]), 32'd0);
    s = cyc; ackd_at = -1;
    req_d(0, 1'b0, 32'h80, 32'h0);
    for (int i = 0; i < 10 && out_d[0]; i++) begin drive_hold(0); tick(0); end
    chk("halt_d_ack_latency", 32'(ackd_at), 32'(s + 3));
    halt_v[0] = 1'b0;
    drain(0, 20);

    // Round-robin with both requesters re-requesting right after each ack.
    ack_who.delete();
    for (int i = 0; i < 60 && ack_who.size() < 4; i++) begin
      if (!out_if[1]) req_if(1, $urandom);
      if (!out_d[1])  req_d(1, 1'($urandom_range(1)), $urandom, $urandom);
      tick(1);
    end
    drain(1, 30);
    chk("rr_ack_count", 32'(ack_who.size() >= 4), 32'd1);
    if (ack_who.size() >= 4)
      for (int i = 0; i < 4; i++) chk("rr_order", 32'(ack_who[i]), 32'(i % 2));

    // Reset in the middle of an access.
    req_if(0, 32'h40);
    tick(0);
    chk("pre_rst_mem_en", 32'(o_mem_en[0]), 32'd1);
    #2;
    rst_b = 1'b0;
    #1;
    chk("async_rst_mem_en", 32'(o_mem_en[0]), 32'd0);
    chk("async_rst_mem_we", 32'(o_mem_we[0]), 32'd0);
    chk("async_rst_busy", 32'(o_busy[0]), 32'd0);
    chk("async_rst_acks", 32'({o_if_ack[0], o_d_ack[0]}), 32'd0);
    model_reset();
    rst_b = 1'b1;
    repeat (3) tick(0);
    chk("post_rst_busy", 32'(o_busy[0]), 32'd0);

    // Randomized traffic on both arbitration modes.
    for (int k = 0; k < 2; k++) begin
      repeat (500) begin drive_rand(k); tick(k); end
      halt_v[k] = 1'b0;
      drain(k, 40);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-ported, fixed-latency, byte-lane memory between the core's instruction-fetch port and its data (load/store) port.
- Sequences each access through a small state machine and returns a one-cycle acknowledge to the owning requester.
- Sits between mips_core's inst/mem ports and the unified memory model; the core stalls while its request is un-acked.

Parameters:
- MEM_LATENCY, 2, cycles from memory enable to read data valid or write committed; legal range 1..15.
- DATA_PRIO, 1, 1 = data port has fixed priority; 0 = round-robin on conflict.

Ports:
- clk  in  1  clock, rising edge.
- rst_b  in  1  reset, asynchronous, active-low.
- halt  in  1  core halted; blocks new fetch grants.
- if_req  in  1  fetch request, held until if_ack.
- if_addr  in  32  fetch byte address.
- if_rdata  out  4x8  fetched bytes [0:3].
- if_ack  out  1  one-cycle pulse; if_rdata valid.
- d_req  in  1  data request, held until d_ack.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  32  data byte address.
- d_wdata  in  4x8  store bytes [0:3].
- d_rdata  out  4x8  load bytes [0:3].
- d_ack  out  1  one-cycle pulse.
- mem_en  out  1  memory access strobe.
- mem_addr  out  32  memory address.
- mem_data_in  out  4x8  write bytes to memory.
- mem_write_en  out  1  write strobe, qualified by mem_en.
- mem_data_out  in  4x8  read bytes from memory.
- busy  out  1  state != ARB_IDLE.

Behaviour:
- Reset (async, rst_b=0): state ARB_IDLE; all outputs 0, including rdata registers; last_grant = OWNER_D; counter 0. Reset mid-access aborts immediately with no ack. mem_en and mem_write_en drop asynchronously.
- ARB_IDLE, at each edge, considers eligible requests. Fetch is eligible only if if_req=1 and halt=0; data is eligible if d_req=1.
  - Only one eligible: grant it.
  - Both eligible, DATA_PRIO=1: grant data.
  - Both eligible, DATA_PRIO=0: grant the owner not equal to last_grant.
  - On grant: latch owner, address, we, wdata; update last_grant; cnt = MEM_LATENCY-1; go to ARB_ACCESS.
- ARB_ACCESS:
  - mem_en=1 and mem_addr/mem_data_in driven from latched values during the first ACCESS cycle only.
  - mem_write_en=1 in that same cycle if latched we=1; 0 otherwise.
  - cnt decrements each cycle. At the edge with cnt==0, a read captures mem_data_out into the owner's rdata register; then go to ARB_DONE.
- ARB_DONE: pulse the owner's ack for exactly one cycle; go to ARB_IDLE. Requests are ignored in ARB_DONE, so a requester dropping req on ack is never re-granted.
- Latency: request seen at edge N -> mem_en during cycle N+1 -> ack during cycle N+MEM_LATENCY+1. Next grant is possible at the edge ending the ack's following IDLE cycle.
- Stores never modify d_rdata. if_rdata and d_rdata hold their value until the next read by that owner.
- Requester drops req mid-access: the access completes and the ack still pulses.
- halt rising during a fetch access: that fetch completes; no further fetches are granted. Data requests are still served.
- Address alignment is not checked; the address is passed through unchanged.
- Counter width: $clog2(MEM_LATENCY+1).

Decomposition:
- Package mem_arb_pkg holds:
  - typedef enum arb_state_t {ARB_IDLE, ARB_ACCESS, ARB_DONE};
  - typedef enum owner_t {OWNER_IF, OWNER_D};
  - typedef byte_lanes_t = 4x8 array.
- Sub-module arb_pick (combinational): inputs eligible_if, eligible_d, last_grant, DATA_PRIO; outputs grant_valid, grant_owner. Unit-testable in isolation.

Test Plan:
- Reset: drive rst_b=0 mid-ACCESS with MEM_LATENCY=2 -> mem_en, acks and busy go 0 without a clock edge; state is ARB_IDLE after release.
- Single fetch: if_req=1, if_addr=0x40, memory returns 8C,01,00,04 -> mem_en high for exactly 1 cycle with mem_addr=0x40; if_ack 3 cycles after grant edge; if_rdata=8C,01,00,04.
- Conflict, DATA_PRIO=1: if_req and d_req (load 0x100) rise together -> data served first (d_ack at cycle 3), fetch mem_en at cycle 5, if_ack at cycle 7.
- Round-robin, DATA_PRIO=0: both requests re-asserted immediately after each ack -> grant order IF, D, IF, D; no port waits more than one foreign access.
- Store: d_we=1, d_addr=0x200, d_wdata=DE,AD,BE,EF -> mem_write_en=1 for one cycle with those bytes; d_ack pulses once; d_rdata unchanged from the prior load.
- Halt: halt=1 with if_req held -> no mem_en for 10 cycles, busy=0. A d_req during halt is still acked after 3 cycles.
